pool_result_reader: RTL and testbench
=====================================

POOL_RESULT_READER -- requirements
Module: pool_result_reader

Interface
REQ-001 SHALL have parameter CHANNELS, default 8, number of output channels read.
REQ-002 SHALL have parameter OUT_DIM, default 14, pooled rows and columns per channel.
REQ-003 SHALL have parameter ROW_STRIDE, default 56, address step between pooled rows (2 rows x 28).
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  one-cycle pulse (driven from pool_done) begins a readout.
REQ-007 rd_en  output  1  memory read strobe.
REQ-008 rd_ch  output  4  channel bank selected for the read.
REQ-009 rd_addr  output  10  address within the bank.
REQ-010 rd_data  input  8  read data, valid exactly 1 cycle after the rd_en cycle.
REQ-011 out_valid  output  1  out_data/out_ch/out_idx/out_last are valid.
REQ-012 out_ready  input  1  consumer accepts the word when out_valid && out_ready.
REQ-013 out_data  output  8  pooled value.
REQ-014 out_ch  output  4  channel of out_data.
REQ-015 out_idx  output  8  position in channel, r*OUT_DIM+c, range 0..195.
REQ-016 out_last  output  1  high on the final word (channel CHANNELS-1, idx 195).
REQ-017 busy  output  1  high from the cycle after accepted start until done.
REQ-018 done  output  1  one-cycle pulse after the last handshake.

Function
REQ-019 SHALL use states IDLE, RUN, FLUSH: IDLE->RUN on start; RUN->FLUSH after the last read issues; FLUSH->IDLE on out_last handshake.
REQ-020 SHALL read in channel-major order: ch 0..CHANNELS-1, r 0..OUT_DIM-1, c 0..OUT_DIM-1.
REQ-021 SHALL compute rd_addr = r*ROW_STRIDE + 2*c (first 0, last 754 at defaults).
REQ-022 SHALL issue a read only when buffered words plus in-flight reads < 2.
REQ-023 SHALL capture rd_data into a 2-entry buffer together with its ch, idx and last tags.
REQ-024 SHALL keep all out_* stable while out_valid && !out_ready.
REQ-025 SHALL sustain one word per cycle with out_ready held high.
REQ-026 SHALL raise out_valid for the first word 2 cycles after the start cycle.
REQ-027 SHALL ignore start while busy.
REQ-028 SHALL never issue rd_en outside RUN, and never more than CHANNELS*OUT_DIM*OUT_DIM reads per readout.
REQ-029 SHALL return to IDLE and drive done in the cycle after the out_last handshake; start in that done cycle is accepted.

Reset
REQ-030 On rst low, asynchronously: state IDLE, counters 0, buffer empty, rd_en, out_valid, out_last, busy, done 0; out_data, out_ch, out_idx 0.
REQ-031 Reset mid-readout SHALL discard all buffered and in-flight data; the rd_data returned after reset SHALL be ignored.

Configuration
REQ-032 Macro READER_CHECKSUM_EN defined: adds output checksum[15:0], the mod-2^16 sum of every transferred out_data, cleared on accepted start, final value valid when done is high.
REQ-033 Macro undefined: no checksum port and no accumulator logic.

Structure
REQ-034 CHANNELS, OUT_DIM, ROW_STRIDE defaults and the state encoding SHALL live in the shared CNN package.
REQ-035 The 2-entry tagged buffer SHALL be a sub-module, reader_skid_buf; address generation and FSM stay in the top.

Verification
REQ-036 Memory model with bank ch at addr a = (ch*16 + a) mod 256, out_ready=1 -> 1568 words, one per cycle; word 1 = ch0 addr 2 = 0x02; word 14 = ch0 idx14 addr 56 = 0x38; done 1 cycle after out_last.
REQ-037 out_ready toggled 1/0 each cycle -> no word lost or duplicated; outputs stable during stall; order matches REQ-020.
REQ-038 out_ready held 0 for 20 cycles after start -> at most 2 reads issued; rd_en low until ready returns.
REQ-039 start repeated at cycle 100 of a readout -> ignored; word count still 1568.
REQ-040 rst low at word 500, then start -> new readout begins at ch0 idx0, no stale words.
REQ-041 With READER_CHECKSUM_EN and all banks 0x01 -> checksum = 1568 (0x0620) when done is high.

Source files
------------

// File: rtl/pool_result_reader_pkg.sv
// Shared CNN definitions for the pooled-result readout: geometry defaults, FSM states and the tagged word.
package pool_result_reader_pkg;

  localparam int unsigned CHANNELS_DEF   = 8;
  localparam int unsigned OUT_DIM_DEF    = 14;
  localparam int unsigned ROW_STRIDE_DEF = 56;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } reader_state_t;

  typedef struct packed {
    logic [7:0] data;
    logic [3:0] ch;
    logic [7:0] idx;
    logic       last;
  } tagged_word_t;

endpackage

// File: rtl/reader_skid_buf.sv
// Two-entry tagged output buffer; presents the arriving word directly when empty so a
// word is visible in the same cycle the memory returns it.
module reader_skid_buf
  import pool_result_reader_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  tagged_word_t in_word,
  input  logic         out_ready,
  output logic         out_valid,
  output tagged_word_t out_word,
  output logic [1:0]   count
);

  tagged_word_t mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic         push;
  logic         pop;

  assign out_valid = (count != 2'd0) || in_valid;

  always_comb begin
    out_word = '0;
    if (count != 2'd0)
      out_word = mem[rd_ptr];
    else if (in_valid)
      out_word = in_word;
  end

  // A word arriving into an empty buffer and taken the same cycle is never stored.
  assign pop  = out_ready && (count != 2'd0);
  assign push = in_valid && ((count != 2'd0) || !out_ready);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count  <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count <= count + 2'(push) - 2'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_word;
  end

endmodule

// File: rtl/pool_result_reader.sv
// Streams pooled results out of the per-channel banks in channel-major order.
// Optional macro READER_CHECKSUM_EN adds a running 16-bit checksum of transferred words.
module pool_result_reader
  import pool_result_reader_pkg::*;
#(
  parameter int unsigned CHANNELS   = CHANNELS_DEF,
  parameter int unsigned OUT_DIM    = OUT_DIM_DEF,
  parameter int unsigned ROW_STRIDE = ROW_STRIDE_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        rd_en,
  output logic [3:0]  rd_ch,
  output logic [9:0]  rd_addr,
  input  logic [7:0]  rd_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic [3:0]  out_ch,
  output logic [7:0]  out_idx,
  output logic        out_last,
  output logic        busy,
  output logic        done
`ifdef READER_CHECKSUM_EN
  ,
  output logic [15:0] checksum
`endif
);

  reader_state_t state, state_nxt;
  logic [3:0]    ch_cnt;
  logic [7:0]    row_cnt;
  logic [7:0]    col_cnt;
  logic [7:0]    idx_cnt;
  logic [9:0]    row_base;
  logic          infl_valid;
  logic [3:0]    infl_ch;
  logic [7:0]    infl_idx;
  logic          infl_last;
  logic [1:0]    buf_count;
  logic          col_end, row_end, last_read;
  logic          start_acc, issue, hs;
  tagged_word_t  in_word, head;

  assign col_end   = (col_cnt == 8'(OUT_DIM - 1));
  assign row_end   = (row_cnt == 8'(OUT_DIM - 1));
  assign last_read = col_end && row_end && (ch_cnt == 4'(CHANNELS - 1));
  assign start_acc = (state == IDLE) && start;
  // At most two words buffered or outstanding, so the buffer can never overflow.
  assign issue     = (state == RUN) && ((3'(buf_count) + 3'(infl_valid)) < 3'd2);
  assign hs        = out_valid && out_ready;

  assign rd_en   = issue;
  assign rd_ch   = ch_cnt;
  assign rd_addr = row_base + 10'({col_cnt, 1'b0});
  assign busy    = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)               state_nxt = RUN;
      RUN:     if (issue && last_read)  state_nxt = FLUSH;
      FLUSH:   if (hs && out_last)      state_nxt = IDLE;
      default:                          state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      ch_cnt     <= '0;
      row_cnt    <= '0;
      col_cnt    <= '0;
      idx_cnt    <= '0;
      row_base   <= '0;
      infl_valid <= 1'b0;
      infl_ch    <= '0;
      infl_idx   <= '0;
      infl_last  <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_nxt;
      done       <= (state == FLUSH) && hs && out_last;
      infl_valid <= issue;
      if (issue) begin
        infl_ch   <= ch_cnt;
        infl_idx  <= idx_cnt;
        infl_last <= last_read;
      end
      if (start_acc) begin
        ch_cnt   <= '0;
        row_cnt  <= '0;
        col_cnt  <= '0;
        idx_cnt  <= '0;
        row_base <= '0;
      end else if (issue) begin
        idx_cnt <= (col_end && row_end) ? '0 : idx_cnt + 8'd1;
        if (!col_end) begin
          col_cnt <= col_cnt + 8'd1;
        end else begin
          col_cnt <= '0;
          if (row_end) begin
            row_cnt  <= '0;
            row_base <= '0;
            ch_cnt   <= ch_cnt + 4'd1;
          end else begin
            row_cnt  <= row_cnt + 8'd1;
            row_base <= row_base + 10'(ROW_STRIDE);
          end
        end
      end
    end
  end

  assign in_word = '{data: rd_data, ch: infl_ch, idx: infl_idx, last: infl_last};

  reader_skid_buf u_buf (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (infl_valid),
    .in_word   (in_word),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_word  (head),
    .count     (buf_count)
  );

  assign out_data = head.data;
  assign out_ch   = head.ch;
  assign out_idx  = head.idx;
  assign out_last = head.last;

`ifdef READER_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      checksum <= '0;
    else if (start_acc)
      checksum <= '0;
    else if (hs)
      checksum <= checksum + 16'(out_data);
  end
`endif

endmodule

// File: tb/tb_pool_result_reader.sv
// Self-checking bench for pool_result_reader: arithmetic reference of the readout order,
// tabulated spot words and ready patterns, plus stall, restart and reset sequences.
module tb_pool_result_reader;

  localparam int CH    = 8;
  localparam int OD    = 14;
  localparam int RS    = 56;
  localparam int PER   = OD * OD;
  localparam int TOTAL = CH * PER;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       rd_en;
  logic [3:0] rd_ch;
  logic [9:0] rd_addr;
  logic [7:0] rd_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [3:0] out_ch;
  logic [7:0] out_idx;
  logic       out_last;
  logic       busy;
  logic       done;
`ifdef READER_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  pool_result_reader #(.CHANNELS(CH), .OUT_DIM(OD), .ROW_STRIDE(RS)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .rd_en     (rd_en),
    .rd_ch     (rd_ch),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
`ifdef READER_CHECKSUM_EN
    ,
    .checksum  (checksum)
`endif
  );

  always #5 clk = ~clk;

  logic mem_ones = 1'b0;

  // Bank memory: one-cycle read latency, garbage when not read.
  always_ff @(posedge clk) begin
    if (rd_en)
      rd_data <= mem_ones ? 8'h01 : 8'((int'(rd_ch) * 16 + int'(rd_addr)) % 256);
    else
      rd_data <= 8'($urandom);
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int words_seen, reads_seen, done_cnt, done_cyc, last_hs_cyc, first_valid_cyc, start_cyc;
  logic tog = 1'b0;
  logic p_stall = 1'b0;
  logic [7:0] p_data;
  logic [3:0] p_ch;
  logic [7:0] p_idx;
  logic p_last;
  int cap_data [TOTAL];
  int cap_ch   [TOTAL];
  int cap_idx  [TOTAL];
  int cap_last [TOTAL];

  function automatic int exp_ch(input int k);   return k / PER; endfunction
  function automatic int exp_idx(input int k);  return k % PER; endfunction
  function automatic int exp_addr(input int k);
    int i;
    i = k % PER;
    return (i / OD) * RS + 2 * (i % OD);
  endfunction
  function automatic int exp_data(input int k);
    return mem_ones ? 1 : (exp_ch(k) * 16 + exp_addr(k)) % 256;
  endfunction

  function automatic logic ready_for(input int mode);
    case (mode)
      0:       return 1'b1;
      1:       begin tog = ~tog; return tog; end
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input logic rdy, input logic st);
    @(negedge clk);
    out_ready = rdy;
    start     = st;
    #1;
    cyc++;
    if (p_stall) begin
      chk("stall_valid", out_valid, 1);
      chk("stall_data", out_data, p_data);
      chk("stall_ch", out_ch, p_ch);
      chk("stall_idx", out_idx, p_idx);
      chk("stall_last", out_last, p_last);
    end
    if (rd_en) begin
      chk("rd_while_busy", busy, 1);
      if (reads_seen < TOTAL) begin
        chk("rd_ch", rd_ch, exp_ch(reads_seen));
        chk("rd_addr", rd_addr, exp_addr(reads_seen));
      end else begin
        chk("read_overrun", reads_seen + 1, TOTAL);
      end
      reads_seen++;
    end
    if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (out_valid && out_ready) begin
      if (words_seen < TOTAL) begin
        chk("word_data", out_data, exp_data(words_seen));
        chk("word_ch", out_ch, exp_ch(words_seen));
        chk("word_idx", out_idx, exp_idx(words_seen));
        chk("word_last", out_last, (words_seen == TOTAL - 1) ? 1 : 0);
        cap_data[words_seen] = out_data;
        cap_ch[words_seen]   = out_ch;
        cap_idx[words_seen]  = out_idx;
        cap_last[words_seen] = out_last;
      end else begin
        chk("word_overrun", words_seen + 1, TOTAL);
      end
      words_seen++;
      if (out_last) last_hs_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    p_stall = out_valid && !out_ready;
    p_data  = out_data;
    p_ch    = out_ch;
    p_idx   = out_idx;
    p_last  = out_last;
  endtask

  task automatic start_readout(input logic rdy);
    words_seen      = 0;
    reads_seen      = 0;
    done_cnt        = 0;
    done_cyc        = -1;
    last_hs_cyc     = -1;
    first_valid_cyc = -1;
    step(rdy, 1'b1);
    start_cyc = cyc;
  endtask

  task automatic finish_readout(input int mode);
    int n;
    n = 0;
    while (done_cnt == 0 && n < 20000) begin
      step(ready_for(mode), 1'b0);
      n++;
    end
    chk("done_seen", done_cnt, 1);
    chk("busy_at_done", busy, 0);
    chk("word_count", words_seen, TOTAL);
    chk("read_count", reads_seen, TOTAL);
    chk("done_after_last", done_cyc, last_hs_cyc + 1);
    chk("first_valid_latency", first_valid_cyc, start_cyc + 2);
    step(1'b1, 1'b0);
    chk("done_one_cycle", done, 0);
  endtask

  typedef struct {
    int         word;
    logic [7:0] data;
    logic [3:0] ch;
    logic [7:0] idx;
    logic       last;
  } spot_t;

  typedef struct {
    int mode;
    int span;
  } mode_vec_t;

  spot_t     spots [6];
  mode_vec_t modes [3];

  initial begin
    int n;
    spots[0] = '{word: 0,    data: 8'h00, ch: 4'd0, idx: 8'd0,   last: 1'b0};
    spots[1] = '{word: 1,    data: 8'h02, ch: 4'd0, idx: 8'd1,   last: 1'b0};
    spots[2] = '{word: 14,   data: 8'h38, ch: 4'd0, idx: 8'd14,  last: 1'b0};
    spots[3] = '{word: 195,  data: 8'hF2, ch: 4'd0, idx: 8'd195, last: 1'b0};
    spots[4] = '{word: 196,  data: 8'h10, ch: 4'd1, idx: 8'd0,   last: 1'b0};
    spots[5] = '{word: 1567, data: 8'h62, ch: 4'd7, idx: 8'd195, last: 1'b1};
    modes[0] = '{mode: 0, span: TOTAL - 1};
    modes[1] = '{mode: 1, span: -1};
    modes[2] = '{mode: 2, span: -1};

    rst = 1'b0;
    start = 1'b0;
    out_ready = 1'b0;
    #3;
    chk("rst_rd_en", rd_en, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_ch", out_ch, 0);
    chk("rst_out_idx", out_idx, 0);
    @(negedge clk);
    rst = 1'b1;

    for (int m = 0; m < 3; m++) begin
      start_readout(ready_for(modes[m].mode));
      finish_readout(modes[m].mode);
      if (modes[m].span >= 0) begin
        chk("stream_span", last_hs_cyc - (start_cyc + 2), modes[m].span);
        for (int s = 0; s < 6; s++) begin
          chk("spot_data", cap_data[spots[s].word], int'(spots[s].data));
          chk("spot_ch", cap_ch[spots[s].word], int'(spots[s].ch));
          chk("spot_idx", cap_idx[spots[s].word], int'(spots[s].idx));
          chk("spot_last", cap_last[spots[s].word], int'(spots[s].last));
        end
      end
    end

    // Consumer stalled for 20 cycles: only two reads may be outstanding.
    start_readout(1'b0);
    repeat (20) step(1'b0, 1'b0);
    chk("stall_reads", reads_seen, 2);
    chk("stall_words", words_seen, 0);
    chk("stall_rd_en_low", rd_en, 0);
    chk("stall_valid_held", out_valid, 1);
    finish_readout(0);

    // Start pulse 100 cycles into a readout is ignored.
    start_readout(1'b1);
    repeat (99) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    chk("restart_busy", busy, 1);
    finish_readout(0);

    // Asynchronous reset at word 500, then a clean readout from the top.
    start_readout(1'b1);
    n = 0;
    while (words_seen < 500 && n < 5000) begin
      step(1'b1, 1'b0);
      n++;
    end
    chk("reached_word_500", words_seen, 500);
    #1 rst = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_rd_en", rd_en, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_out_data", out_data, 0);
    chk("mid_rst_out_idx", out_idx, 0);
    @(negedge clk);
    rst = 1'b1;
    p_stall = 1'b0;
    repeat (3) begin
      step(1'b1, 1'b0);
      chk("post_rst_no_valid", out_valid, 0);
      chk("post_rst_no_rd", rd_en, 0);
    end
    start_readout(1'b1);
    finish_readout(0);

`ifdef READER_CHECKSUM_EN
    mem_ones = 1'b1;
    start_readout(1'b1);
    n = 0;
    while (done_cnt == 0 && n < 20000) begin
      step(1'b1, 1'b0);
      n++;
    end
    chk("checksum_done_seen", done_cnt, 1);
    chk("checksum_value", checksum, 16'h0620);
    mem_ones = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
